multi_reg_loader: RTL and testbench

- Parametrised successor to the two-register nibble-serial weight/data loader.
- Loads any of NUM_REGS equal-width registers over a LANE_W-bit lane using an explicit framed transfer: start, beat counting, atomic commit and a done pulse.
- Adds features the earlier loader lacks: serial readback of a register, per-register clear, abort/restart and out-of-range select detection.
- Sits between the tile's ui_in pins and the compute datapath, which reads the flattened regs bus.

---
 rtl/multi_reg_loader.sv | 192 +++++++++++++++++++
 tb/tb_multi_reg_loader.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_reg_loader.sv
// multi_reg_loader
//   Loads any of NUM_REGS registers (REG_W bits each) over a LANE_W-bit lane
//   using framed transfers. Load frames shift beats into a shadow register and
//   commit it atomically after the last beat. Readback frames stream a register
//   out MS lane first. A start while busy aborts and restarts. Clear zeroes one
//   register. An out-of-range select is rejected with a sel_err pulse.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start, mode, sel    frame request (mode 0 = load, 1 = readback), target index
//   din, din_valid      load data beat
//   clear               zero the register selected by sel (idle only)
//   dout, dout_valid    readback beat
//   busy, done          frame in progress / one-cycle completion pulse
//   sel_err             one-cycle pulse on start/clear with sel >= NUM_REGS
//   regs                committed registers, register i at [i*REG_W +: REG_W]
module multi_reg_loader #(
  parameter int LANE_W   = 4,
  parameter int REG_W    = 32,
  parameter int NUM_REGS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [LANE_W-1:0]         din,
  input  logic                      din_valid,
  input  logic                      clear,
  output logic [LANE_W-1:0]         dout,
  output logic                      dout_valid,
  output logic                      busy,
  output logic                      done,
  output logic                      sel_err,
  output logic [NUM_REGS*REG_W-1:0] regs
);

  localparam int BEATS = REG_W / LANE_W;
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BEATS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_READ = 2'd2;

  logic [1:0]                state_q, state_d;
  logic [SEL_W-1:0]          sel_q, sel_d;
  logic [REG_W-1:0]          shadow_q, shadow_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [NUM_REGS*REG_W-1:0] regs_q, regs_d;
  logic [LANE_W-1:0]         dout_q, dout_d;
  logic                      dout_valid_q, dout_valid_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      sel_err_q, sel_err_d;

  logic [31:0]      sel_ext;
  logic             sel_ok;
  logic [REG_W-1:0] sel_word;
  logic [REG_W-1:0] shadow_in;

  assign sel_ext   = 32'(sel);
  assign sel_ok    = sel_ext < 32'(NUM_REGS);
  // Shadow with the current beat appended in the LS lane; after BEATS beats
  // the first beat has walked up to the MS lane.
  assign shadow_in = (shadow_q << LANE_W) | REG_W'(din);

  // Register addressed by the sel input, used to seed a readback frame.
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (SEL_W'(i) == sel) sel_word = regs_q[i*REG_W +: REG_W];
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    shadow_d     = shadow_q;
    cnt_d        = cnt_q;
    regs_d       = regs_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    sel_err_d    = 1'b0;

    if (start && !sel_ok) sel_err_d = 1'b1;

    if (start && sel_ok) begin
      // A valid start always (re)starts a frame, abandoning any frame in flight.
      sel_d  = sel;
      busy_d = 1'b1;
      if (!mode) begin
        state_d  = S_LOAD;
        shadow_d = '0;
        cnt_d    = '0;
      end else begin
        // The first beat is issued straight from the register so it appears
        // in the cycle right after start.
        state_d      = S_READ;
        shadow_d     = sel_word << LANE_W;
        dout_d       = sel_word[REG_W-1 -: LANE_W];
        dout_valid_d = 1'b1;
        cnt_d        = CNT_W'(1);
        done_d       = (BEATS == 1);
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (clear && !start) begin
            if (sel_ok) begin
              for (int i = 0; i < NUM_REGS; i++) begin
                if (SEL_W'(i) == sel) regs_d[i*REG_W +: REG_W] = '0;
              end
            end else begin
              sel_err_d = 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (din_valid) begin
            shadow_d = shadow_in;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
              for (int i = 0; i < NUM_REGS; i++) begin
                if (SEL_W'(i) == sel_q) regs_d[i*REG_W +: REG_W] = shadow_in;
              end
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = S_IDLE;
              cnt_d   = '0;
            end
          end
        end
        S_READ: begin
          // One extra cycle after the last beat keeps busy high alongside done.
          if (cnt_q == FULL) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end else begin
            dout_d       = shadow_q[REG_W-1 -: LANE_W];
            shadow_d     = shadow_q << LANE_W;
            dout_valid_d = 1'b1;
            cnt_d        = cnt_q + 1'b1;
            done_d       = (cnt_q == LAST);
          end
        end
        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sel_q        <= '0;
      shadow_q     <= '0;
      cnt_q        <= '0;
      regs_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      sel_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      shadow_q     <= shadow_d;
      cnt_q        <= cnt_d;
      regs_q       <= regs_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      sel_err_q    <= sel_err_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sel_err    = sel_err_q;
  assign regs       = regs_q;

endmodule

// File: tb/tb_multi_reg_loader.sv
// Bench for multi_reg_loader: one instance with NUM_REGS=3 (nibble lane,
// 32-bit registers) and one with LANE_W=8, REG_W=128, NUM_REGS=1.
module tb_multi_reg_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A
  logic        start, mode, din_valid, clear;
  logic [1:0]  sel;
  logic [3:0]  din, dout;
  logic        dout_valid, busy, done, sel_err;
  logic [95:0] regs;

  multi_reg_loader #(.LANE_W(4), .REG_W(32), .NUM_REGS(3), .SEL_W(2)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .sel(sel),
    .din(din), .din_valid(din_valid), .clear(clear), .dout(dout),
    .dout_valid(dout_valid), .busy(busy), .done(done), .sel_err(sel_err),
    .regs(regs)
  );

  // Instance B
  logic         b_start, b_mode, b_din_valid, b_clear;
  logic [0:0]   b_sel;
  logic [7:0]   b_din, b_dout;
  logic         b_dout_valid, b_busy, b_done, b_sel_err;
  logic [127:0] b_regs;

  multi_reg_loader #(.LANE_W(8), .REG_W(128), .NUM_REGS(1), .SEL_W(1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .mode(b_mode), .sel(b_sel),
    .din(b_din), .din_valid(b_din_valid), .clear(b_clear), .dout(b_dout),
    .dout_valid(b_dout_valid), .busy(b_busy), .done(b_done), .sel_err(b_sel_err),
    .regs(b_regs)
  );

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [95:0] regs;
    logic        rd;
  } done_t;

  done_t        exp_done[$];
  logic [3:0]   exp_dout[$];
  logic [127:0] exp_b_done[$];
  logic [7:0]   exp_b_dout[$];
  int exp_err = 0, act_err = 0, exp_b_err = 0, act_b_err = 0;
  logic [95:0] exp_regs = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [127:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got %0h with nothing expected", name, act);
  endtask

  // Scoreboard monitors: sample away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dout_valid) begin
        if (exp_dout.size() == 0) unexpected("a_dout", 128'(dout));
        else chk("a_dout", 128'(dout), 128'(exp_dout.pop_front()));
      end
      if (done) begin
        if (exp_done.size() == 0) unexpected("a_done", 128'(regs));
        else begin
          done_t r;
          r = exp_done.pop_front();
          chk("a_done_regs", 128'(regs), 128'(r.regs));
          chk("a_done_with_beat", 128'(dout_valid), 128'(r.rd));
        end
      end
      if (sel_err) act_err++;
      if (b_dout_valid) begin
        if (exp_b_dout.size() == 0) unexpected("b_dout", 128'(b_dout));
        else chk("b_dout", 128'(b_dout), 128'(exp_b_dout.pop_front()));
      end
      if (b_done) begin
        if (exp_b_done.size() == 0) unexpected("b_done", b_regs);
        else chk("b_done_regs", b_regs, exp_b_done.pop_front());
      end
      if (b_sel_err) act_b_err++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drv(input logic st, input logic md, input logic [1:0] s,
                     input logic dv, input logic [3:0] d, input logic cl);
    start = st; mode = md; sel = s; din_valid = dv; din = d; clear = cl;
  endtask

  task automatic cyc(input logic st, input logic md, input logic [1:0] s,
                     input logic dv, input logic [3:0] d, input logic cl);
    drv(st, md, s, dv, d, cl);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 4'h0, 0);
  endtask

  task automatic push_done(input logic rd);
    done_t r;
    r.regs = exp_regs;
    r.rd = rd;
    exp_done.push_back(r);
  endtask

  task automatic a_load(input logic [1:0] s, input logic [31:0] w, input bit gap);
    cyc(1, 0, s, 0, 4'h0, 0);
    exp_regs[s*32 +: 32] = w;
    push_done(1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, s, 1, w[31-4*i -: 4], 0);
      if (gap && i < 7) cyc(0, 0, s, 0, 4'h0, 0);
    end
    idle(2);
  endtask

  task automatic a_read(input logic [1:0] s, input logic [31:0] w);
    for (int i = 0; i < 8; i++) exp_dout.push_back(w[31-4*i -: 4]);
    push_done(1'b1);
    cyc(1, 1, s, 0, 4'h0, 0);
    idle(9);
  endtask

  task automatic bcyc(input logic st, input logic md, input logic s,
                      input logic dv, input logic [7:0] d, input logic cl);
    b_start = st; b_mode = md; b_sel = s; b_din_valid = dv; b_din = d; b_clear = cl;
    @(posedge clk); #1;
  endtask

  initial begin
    drv(0, 0, 0, 0, 4'h0, 0);
    b_start = 0; b_mode = 0; b_sel = 0; b_din_valid = 0; b_din = 0; b_clear = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_regs", 128'(regs), 128'h0);
    chk("rst_busy", 128'(busy), 128'h0);
    chk("rst_outs", 128'({dout, dout_valid, done, sel_err}), 128'h0);
    rst_n = 1'b1;
    idle(1);
    chk("post_rst_busy", 128'(busy), 128'h0);

    // Load 0x12345678 into register 2 on consecutive beats.
    cyc(1, 0, 2, 0, 4'h0, 0);
    chk("load_busy", 128'(busy), 128'h1);
    exp_regs[64 +: 32] = 32'h12345678;
    push_done(1'b0);
    for (int i = 1; i <= 8; i++) begin
      chk("load_no_commit", 128'(regs), 128'h0);
      cyc(0, 0, 2, 1, 4'(i), 0);
    end
    chk("load_done", 128'(done), 128'h1);
    chk("load_regs", 128'(regs), 128'h12345678_00000000_00000000);
    chk("load_busy_low", 128'(busy), 128'h0);
    idle(1);
    chk("load_done_once", 128'(done), 128'h0);

    // Stalled load of register 0, then readback.
    a_load(0, 32'h12345678, 1);
    for (int i = 1; i <= 8; i++) exp_dout.push_back(4'(i));
    push_done(1'b1);
    cyc(1, 1, 0, 0, 4'h0, 0);
    idle(7);
    chk("read_busy_last", 128'(busy), 128'h1);
    idle(1);
    chk("read_busy_after", 128'(busy), 128'h0);
    chk("read_valid_after", 128'(dout_valid), 128'h0);
    idle(2);

    // Start in the same cycle as the final load beat: abort wins.
    cyc(1, 0, 0, 0, 4'h0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 1, 4'hF, 0);
    for (int i = 1; i <= 8; i++) exp_dout.push_back(4'(i));
    push_done(1'b1);
    cyc(1, 1, 0, 1, 4'hF, 0);
    idle(9);
    chk("collide_reg0", 128'(regs[31:0]), 128'h12345678);

    // Aborted read restarts on register 2.
    exp_dout.push_back(4'h1); exp_dout.push_back(4'h2); exp_dout.push_back(4'h3);
    for (int i = 1; i <= 8; i++) exp_dout.push_back(4'(i));
    push_done(1'b1);
    cyc(1, 1, 0, 0, 4'h0, 0);
    idle(2);
    cyc(1, 1, 2, 0, 4'h0, 0);
    idle(9);

    // Abort a load after 3 beats and restart with all-ones.
    a_load(1, 32'hAAAAAAAA, 0);
    cyc(1, 0, 1, 0, 4'h0, 0);
    for (int i = 1; i <= 3; i++) cyc(0, 0, 1, 1, 4'(i), 0);
    cyc(1, 0, 1, 0, 4'h0, 0);
    exp_regs[32 +: 32] = 32'hFFFFFFFF;
    push_done(1'b0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 1, 4'hF, 0);
    idle(2);
    a_load(1, 32'hAAAAAAAA, 0);
    cyc(1, 0, 1, 0, 4'h0, 0);
    for (int i = 1; i <= 3; i++) cyc(0, 0, 1, 1, 4'(i), 0);
    cyc(1, 0, 1, 0, 4'h0, 0);
    idle(3);
    chk("abort_keeps_reg1", 128'(regs[63:32]), 128'hAAAAAAAA);
    chk("abort_still_busy", 128'(busy), 128'h1);
    a_read(1, 32'hAAAAAAAA);

    // Select errors and clear.
    cyc(1, 0, 3, 0, 4'h0, 0);
    exp_err++;
    chk("selerr_pulse", 128'(sel_err), 128'h1);
    chk("selerr_not_busy", 128'(busy), 128'h0);
    idle(1);
    chk("selerr_one_cycle", 128'(sel_err), 128'h0);
    cyc(0, 0, 3, 0, 4'h0, 1);
    exp_err++;
    chk("clear_bad_regs", 128'(regs), 128'(exp_regs));
    cyc(0, 0, 1, 0, 4'h0, 1);
    exp_regs[32 +: 32] = 32'h0;
    chk("clear_reg1", 128'(regs), 128'(exp_regs));
    // Clear of register 2 during a load of register 0 is ignored.
    cyc(1, 0, 0, 0, 4'h0, 0);
    exp_regs[0 +: 32] = 32'h87654321;
    push_done(1'b0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 4'(8 - i), 0);
    cyc(0, 0, 2, 0, 4'h0, 1);
    for (int i = 4; i < 8; i++) cyc(0, 0, 0, 1, 4'(8 - i), 0);
    idle(2);
    // Start and clear together in idle: start wins.
    for (int i = 1; i <= 8; i++) exp_dout.push_back(4'(i));
    push_done(1'b1);
    cyc(1, 1, 2, 0, 4'h0, 1);
    idle(9);
    chk("start_beats_clear", 128'(regs[95:64]), 128'h12345678);

    // Reset in the middle of a load.
    cyc(1, 0, 1, 0, 4'h0, 0);
    cyc(0, 0, 1, 1, 4'hC, 0); cyc(0, 0, 1, 1, 4'hA, 0); cyc(0, 0, 1, 1, 4'hF, 0);
    cyc(0, 0, 1, 1, 4'hE, 0); cyc(0, 0, 1, 1, 4'hF, 0);
    drv(0, 0, 0, 0, 4'h0, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_regs", 128'(regs), 128'h0);
    chk("async_rst_busy", 128'(busy), 128'h0);
    #5 rst_n = 1'b1;
    exp_regs = '0;
    a_load(1, 32'hCAFEF00D, 0);
    chk("reload_regs", 128'(regs), 128'h00000000_CAFEF00D_00000000);

    // Wide-lane instance: 16 byte beats.
    bcyc(1, 0, 0, 0, 8'h0, 0);
    exp_b_done.push_back(128'h000102030405060708090A0B0C0D0E0F);
    for (int i = 0; i < 16; i++) bcyc(0, 0, 0, 1, 8'(i), 0);
    bcyc(0, 0, 0, 0, 8'h0, 0);
    chk("b_regs", b_regs, 128'h000102030405060708090A0B0C0D0E0F);
    for (int i = 0; i < 16; i++) exp_b_dout.push_back(8'(i));
    exp_b_done.push_back(128'h000102030405060708090A0B0C0D0E0F);
    bcyc(1, 1, 0, 0, 8'h0, 0);
    for (int i = 0; i < 17; i++) bcyc(0, 0, 0, 0, 8'h0, 0);
    bcyc(1, 0, 1, 0, 8'h0, 0);
    exp_b_err++;
    chk("b_selerr", 128'(b_sel_err), 128'h1);
    chk("b_selerr_idle", 128'(b_busy), 128'h0);
    for (int i = 0; i < 3; i++) bcyc(0, 0, 0, 0, 8'h0, 0);

    chk("a_selerr_count", 128'(act_err), 128'(exp_err));
    chk("b_selerr_count", 128'(act_b_err), 128'(exp_b_err));
    chk("a_dout_pending", 128'(exp_dout.size()), 128'h0);
    chk("a_done_pending", 128'(exp_done.size()), 128'h0);
    chk("b_dout_pending", 128'(exp_b_dout.size()), 128'h0);
    chk("b_done_pending", 128'(exp_b_done.size()), 128'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
